// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared instruction-format constants and loader state encoding
package instruction_loader_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_B = 2'b10;
  localparam logic [1:0] TYPE_J = 2'b11;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RECV   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    RECV   = ST_RECV,
    WRITE  = ST_WRITE,
    CHECK  = ST_CHECK,
    FINISH = ST_FINISH
  } loader_state_t;
endpackage

// File: rtl/instruction_loader_byte_word_assembler.sv
// instruction_loader_byte_word_assembler: big-endian byte-to-word shifter with 2-bit byte counter and XOR checksum
//   clock/reset : clock, async active-high reset
//   clear       : restart assembly and checksum
//   shift       : accept byte_data this cycle
//   word        : assembled word (first byte ends in [31:24])
//   checksum    : running XOR of every accepted byte
//   last        : current shift completes a word
module instruction_loader_byte_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [7:0]             byte_data,
  output logic [INSTR_WIDTH-1:0] word,
  output logic [7:0]             checksum,
  output logic                   last
);
  logic [1:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      word     <= '0;
      count    <= '0;
      checksum <= '0;
    end else if (clear) begin
      word     <= '0;
      count    <= '0;
      checksum <= '0;
    end else if (shift) begin
      word     <= {word[INSTR_WIDTH-9:0], byte_data};
      count    <= count + 2'd1;
      checksum <= checksum ^ byte_data;
    end
  assign last = shift && count == 2'd3;
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: loads a host byte stream into instruction memory as big-endian words and verifies an XOR checksum
//   clock/reset      : clock, async active-high reset
//   start/word_count : begin a load of word_count words (ignored unless idle)
//   byte_valid/ready : host byte handshake, byte_data is the payload
//   mem_*            : instruction memory write port (byte address, word aligned)
//   cpu_hold/busy    : high while a load is in progress
//   done             : one-cycle completion pulse; error is sticky until next start
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int BASE_WORD   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8:0]             word_count,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_write_enable,
  output logic [31:0]            mem_address,
  output logic [INSTR_WIDTH-1:0] mem_write_data,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);
  loader_state_t state, state_next;
  logic [8:0] word_index, remaining;
  logic [7:0] checksum;
  logic       last, transfer, accept, overflow;
  logic [9:0] end_word;
  assign transfer = byte_valid && byte_ready;
  assign accept   = state == IDLE && start;
  assign end_word = 10'(BASE_WORD) + {1'b0, word_count};
  assign overflow = end_word > 10'(DEPTH_WORDS);
  instruction_loader_byte_word_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (accept),
    .shift     (state == RECV && transfer),
    .byte_data (byte_data),
    .word      (mem_write_data),
    .checksum  (checksum),
    .last      (last)
  );
  always_comb begin
    state_next       = state;
    byte_ready       = state == RECV || state == CHECK;
    mem_write_enable = state == WRITE;
    busy             = state != IDLE;
    cpu_hold         = state != IDLE;
    done             = state == FINISH;
    case (state)
      IDLE:    if (start) state_next = overflow ? FINISH : word_count == 9'd0 ? CHECK : RECV;
      RECV:    if (last) state_next = WRITE;
      WRITE:   state_next = remaining > 9'd1 ? RECV : CHECK;
      CHECK:   if (transfer) state_next = FINISH;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state      <= IDLE;
      word_index <= '0;
      remaining  <= '0;
      error      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        remaining  <= word_count;
        word_index <= 9'(BASE_WORD);
        error      <= overflow;
      end
      if (state == WRITE) begin
        word_index <= word_index + 9'd1;
        remaining  <= remaining - 9'd1;
      end
      if (state == CHECK && transfer && byte_data != checksum) error <= 1'b1;
    end
  assign mem_address = {21'd0, word_index, 2'b00};
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed scoreboard bench for instruction_loader
module tb_instruction_loader;
  logic        clock = 0, reset = 1, start = 0, byte_valid = 0;
  logic [8:0]  word_count = 0;
  logic [7:0]  byte_data = 0;
  logic        byte_ready, mem_write_enable, cpu_hold, busy, done, error;
  logic [31:0] mem_address, mem_write_data;
  int n_checks = 0, n_fail = 0, n_writes = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prog[$];
  bit watch_hold = 0, hold_dropped = 0;

  instruction_loader dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (watch_hold && !cpu_hold) hold_dropped = 1;
    if (mem_write_enable === 1'b1) begin
      n_writes++;
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_address", 64'(mem_address), 64'(e[63:32]));
        check("write_data", 64'(mem_write_data), 64'(e[31:0]));
      end
    end
  end

  function automatic logic [7:0] xsum();
    logic [7:0] x = 0;
    foreach (prog[i]) x ^= prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    byte_valid = 1;
    byte_data  = b;
    while (!byte_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("byte_ready", 64'(byte_ready), 64'd1);
    @(posedge clock);
    #1 byte_valid = 0;
  endtask

  task automatic do_start(input logic [8:0] n, input logic exp_err);
    @(negedge clock);
    start = 1;
    word_count = n;
    @(negedge clock);
    start = 0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("error_after_start", 64'(error), 64'(exp_err));
  endtask

  task automatic wait_done(input logic exp_err);
    int t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_finish", 64'(busy), 64'd1);
    check("error_at_done", 64'(error), 64'(exp_err));
    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'({busy, cpu_hold}), 64'd0);
  endtask

  task automatic run_load(input logic [7:0] ck, input logic exp_err, input int gap, input bit mid);
    do_start(9'(prog.size()), 1'b0);
    watch_hold = 1;
    foreach (prog[i]) begin
      exp_q.push_back({32'((i + 1) * 4), prog[i]});
      for (int b = 0; b < 4; b++) begin
        send_byte(prog[i][31 - 8 * b -: 8], gap > 0 ? int'($urandom_range(0, gap)) : 0);
        if (mid && i == 0 && b == 2) begin
          @(negedge clock);
          start = 1;
          word_count = 9'd7;
          @(negedge clock);
          start = 0;
        end
      end
    end
    send_byte(ck, gap > 0 ? int'($urandom_range(0, gap)) : 0);
    @(negedge clock);
    wait_done(exp_err);
    watch_hold = 0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w0;
    repeat (2) @(negedge clock);
    check("reset_outputs", {byte_ready, mem_write_enable, busy, cpu_hold, done, error, mem_address, mem_write_data}, 64'd0);
    reset = 0;
    prog = '{32'h08022000, 32'h08043800};
    w0 = n_writes;
    run_load(xsum(), 1'b0, 0, 0);
    check("writes_good", 64'(n_writes - w0), 64'd2);
    w0 = n_writes;
    run_load(8'h00, 1'b1, 0, 0);
    check("writes_bad_ck", 64'(n_writes - w0), 64'd2);
    repeat (3) @(negedge clock);
    check("error_sticky", 64'(error), 64'd1);
    w0 = n_writes;
    do_start(9'd256, 1'b1);
    check("overflow_done", 64'({done, error}), 64'b11);
    @(negedge clock);
    check("overflow_idle", 64'(busy), 64'd0);
    check("overflow_no_write", 64'(n_writes - w0), 64'd0);
    w0 = n_writes;
    do_start(9'd0, 1'b0);
    send_byte(8'h00, 0);
    @(negedge clock);
    wait_done(1'b0);
    check("zero_no_write", 64'(n_writes - w0), 64'd0);
    w0 = n_writes;
    hold_dropped = 0;
    run_load(xsum(), 1'b0, 3, 1);
    check("gap_writes", 64'(n_writes - w0), 64'd2);
    check("hold_throughout", 64'(hold_dropped), 64'd0);
    prog = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    w0 = n_writes;
    do_start(9'd3, 1'b0);
    exp_q.push_back({32'd4, prog[0]});
    for (int k = 0; k < 6; k++) send_byte(prog[k / 4][31 - 8 * (k % 4) -: 8], 0);
    reset = 1;
    #1;
    check("reset_midload", {byte_ready, mem_write_enable, busy, cpu_hold, done, error, mem_address, mem_write_data}, 64'd0);
    check("reset_one_write", 64'(n_writes - w0), 64'd1);
    check("reset_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    reset = 0;
    prog = '{32'hCAFEF00D};
    run_load(xsum(), 1'b0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
